// File: rtl/au_seq.sv
// WIDTH-generic arithmetic unit: add, subtract, pass, shift-add multiply and
// restoring divide behind one START/BUSY/DONE handshake with registered result and flags.
module au_seq #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               LdA,
    input  logic               LdB,
    input  logic [2*WIDTH-1:0] X,
    input  logic [3:0]         OP,
    input  logic               START,
    output logic [2*WIDTH-1:0] Rout,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVR,
    output logic               ZERO,
    output logic               COUT,
    output logic               DZ
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_PASS = 4'd4;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state;
    logic [2*W-1:0]    a_reg;
    logic [W-1:0]      b_reg;
    logic [2*W-1:0]    a_lat;
    logic [W-1:0]      b_lat;
    logic [3:0]        op_lat;
    logic [2*W-1:0]    wk;
    logic [CW-1:0]     cnt;

    logic [W:0]        mul_sum;
    logic [2*W-1:0]    mul_next;
    logic [W:0]        div_sh;
    logic [W:0]        div_dif;
    logic [2*W-1:0]    div_next;

    logic [W+1:0]      as_res;
    logic [2*W-1:0]    res;
    logic              res_ovr;
    logic              res_cout;
    logic              res_dz;

    logic              div_fast;

    // Returns {signed overflow, carry out, W-bit sum}; subtraction is x + ~y + 1.
    function automatic logic [W+1:0] addsub(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic         sub);
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic [W-1:0] low;
        yy   = sub ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sub};
        low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + {{(W-1){1'b0}}, sub};
        return {low[W-1] ^ full[W], full[W], full[W-1:0]};
    endfunction

    // One shift-add / restoring-divide iteration on the shared working register.
    always_comb begin
        mul_sum  = {1'b0, wk[2*W-1:W]} + (wk[0] ? {1'b0, b_lat} : {(W+1){1'b0}});
        mul_next = {mul_sum, wk[W-1:1]};
        div_sh   = {wk[2*W-1:W], wk[W-1]};
        div_dif  = div_sh - {1'b0, b_lat};
        if (div_sh >= {1'b0, b_lat}) begin
            div_next = {div_dif[W-1:0], wk[W-2:0], 1'b1};
        end else begin
            div_next = {div_sh[W-1:0], wk[W-2:0], 1'b0};
        end
    end

    // Divide-by-zero and quotient overflow skip the iterations entirely.
    always_comb begin
        div_fast = (b_reg == '0) || (a_reg[2*W-1:W] >= b_reg);
    end

    always_comb begin
        res      = '0;
        res_ovr  = 1'b0;
        res_cout = 1'b0;
        res_dz   = 1'b0;
        as_res   = addsub(a_lat[W-1:0], b_lat, op_lat == OP_SUB);
        case (op_lat)
            OP_ADD, OP_SUB: begin
                res      = {{W{1'b0}}, as_res[W-1:0]};
                res_cout = as_res[W];
                res_ovr  = as_res[W+1];
            end
            OP_MUL: begin
                res = wk;
            end
            OP_DIV: begin
                if (b_lat == '0) begin
                    res     = '1;
                    res_ovr = 1'b1;
                    res_dz  = 1'b1;
                end else if (a_lat[2*W-1:W] >= b_lat) begin
                    res     = '1;
                    res_ovr = 1'b1;
                end else begin
                    // Working register holds {remainder, quotient}; output swaps them.
                    res = {wk[W-1:0], wk[2*W-1:W]};
                end
            end
            OP_PASS: begin
                res = a_lat;
            end
            default: begin
                res = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            op_lat <= '0;
            wk     <= '0;
            cnt    <= '0;
            Rout   <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            OVR    <= 1'b0;
            ZERO   <= 1'b0;
            COUT   <= 1'b0;
            DZ     <= 1'b0;
        end else begin
            if (LdA) begin
                a_reg <= X;
            end
            if (LdB) begin
                b_reg <= X[W-1:0];
            end

            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        a_lat  <= a_reg;
                        b_lat  <= b_reg;
                        op_lat <= OP;
                        BUSY   <= 1'b1;
                        cnt    <= CW'(W);
                        if (OP == OP_MUL) begin
                            wk    <= {{W{1'b0}}, a_reg[W-1:0]};
                            state <= RUN;
                        end else if (OP == OP_DIV && !div_fast) begin
                            wk    <= a_reg;
                            state <= RUN;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RUN: begin
                    wk  <= (op_lat == OP_MUL) ? mul_next : div_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    Rout  <= res;
                    OVR   <= res_ovr;
                    COUT  <= res_cout;
                    DZ    <= res_dz;
                    ZERO  <= (res == '0);
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/au_seq.md
Name: au_seq

Overview:
- Parametrised successor to the team's fixed 16/8-bit arithmetic unit.
- One WIDTH-generic unit does add, subtract, pass, sequential shift-add multiply and sequential restoring divide.
- All operations use a single START/BUSY/DONE handshake and write one registered result with flags.
- Sits between the operand-entry datapath (X bus with LdA/LdB strobes) and the display/result path.

Parameters:
- WIDTH, 8, operand width W. A is 2W bits; B is W bits; Rout is 2W bits. Legal values 4..32.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- CLR  in  1  asynchronous, active-high reset
- LdA  in  1  load A register from X[2W-1:0] on this edge
- LdB  in  1  load B register from X[W-1:0] on this edge
- X  in  2W  operand entry bus
- OP  in  4  0=ADD, 1=SUB, 2=MUL, 3=DIV, 4=PASS (Rout=A); others=NOP
- START  in  1  request operation; sampled only in IDLE
- Rout  out  2W  registered result
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse when Rout and flags update
- OVR  out  1  overflow / invalid-result flag
- ZERO  out  1  Rout == 0
- COUT  out  1  ADD/SUB carry out (SUB: 1 = no borrow)
- DZ  out  1  divide-by-zero flag

Behaviour:
- Reset: CLR high forces A, B, Rout, all working registers and all flags to 0 immediately, state=IDLE.
  - All outputs read 0 during reset, including ZERO.
  - CLR mid-operation aborts the operation; no DONE is produced.
- Operand loads:
  - LdA/LdB are accepted on any edge, including while BUSY.
  - An operation uses the A, B and OP values captured at the START edge, so later loads do not disturb it.
  - START and LdA on the same edge: the operation uses the old A.
- States: IDLE, RUN, FIN.
  - IDLE --START--> RUN at edge t0. Operands and OP are latched, BUSY=1 from t0, cycle count loaded.
  - RUN performs one iteration per edge.
  - FIN is the edge at which Rout and flags are written. DONE=1 for exactly the following cycle, BUSY=0, return to IDLE.
- Latency, START edge t0 to the Rout-update edge:
  - ADD/SUB/PASS/NOP: t0+1.
  - MUL: t0+W+1.
  - DIV: t0+W+1.
  - Divide-by-zero and divide overflow are detected at t0 and finish at t0+1.
- START while BUSY is ignored. START held high re-triggers on the first IDLE edge after DONE.
- ADD/SUB:
  - Operate on A[W-1:0] and B.
  - Rout = zero-extended W-bit sum/difference; COUT = carry out.
  - OVR = signed overflow, i.e. carry into MSB XOR carry out.
- MUL: unsigned A[W-1:0] x B, 2W-bit product, W iterations of shift-add. OVR=0, COUT=0.
- DIV: unsigned A (2W) / B (W), restoring, W iterations.
  - Rout = {quotient[W-1:0], remainder[W-1:0]}.
  - B==0: Rout = all ones, DZ=1, OVR=1.
  - A[2W-1:W] >= B (quotient does not fit): Rout = all ones, OVR=1, DZ=0.
- PASS: Rout = A; all flags 0 except ZERO.
- NOP: Rout = 0; ZERO=1; other flags 0.
- Flag update rules:
  - ZERO is computed from the new Rout value.
  - Flags and Rout hold until the next FIN or CLR.
  - Flags not applicable to the operation are cleared at FIN.

Test Plan (WIDTH=8):
1. Load A=0x007F, B=0x01, OP=ADD, START -> Rout=0x0080, OVR=1, COUT=0, ZERO=0; DONE exactly 1 cycle after START edge. Then OP=SUB with A=0x0005, B=0x05 -> Rout=0x0000, ZERO=1, COUT=1, OVR=0.
2. A=0x00FF, B=0xFF, OP=MUL, START -> BUSY for 9 cycles, Rout=0xFE01, OVR=0; LdA with 0x1111 at cycle 3 does not change the result; START pulsed at cycle 4 is ignored.
3. A=0x1234, B=0x56, OP=DIV -> Rout=0x3610 (quotient 0x36, remainder 0x10) at t0+9; A=0x0064, B=0x0A -> Rout=0x0A00, ZERO=0.
4. DIV with B=0x00 -> Rout=0xFFFF, DZ=1, OVR=1, DONE at t0+1. DIV with A=0x5600, B=0x56 -> Rout=0xFFFF, OVR=1, DZ=0.
5. Start MUL, assert CLR at cycle 4 asynchronously (mid-cycle) -> all outputs 0 immediately, BUSY=0, no DONE pulse; a fresh MUL 0x0003 x 0x04 afterwards -> 0x000C.
6. Sweep with a reference model (WIDTH=4 exhaustive, WIDTH=16 random 10k vectors) over all ops incl. OP=5..15 (NOP -> Rout=0, ZERO=1) -> Rout and flags match the model; DONE is always one cycle wide and BUSY/DONE are never high together.
